// File: rtl/vector_sequencer_pkg.sv
// Shared definitions for the vector sequencer: FSM state encoding and the
// bit positions of the hazard/turn/side flags inside a ROM vector word.
package vector_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_WAIT  = 3'd2,
        ST_HOLD  = 3'd3,
        ST_DONE  = 3'd4
    } seq_state_e;

    localparam int HAZ_BIT  = 0;
    localparam int TURN_BIT = 1;
    localparam int SIDE_BIT = 2;
    localparam int VEC_W    = 3;
    localparam int MEM_W    = 8;

endpackage

// File: rtl/hold_down_counter.sv
// Loadable down-counter used to time how long a vector is held; decrements on
// an enable and saturates at zero, with a zero flag for the controlling FSM.
module hold_down_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset_i,
    input  logic         clear_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic [W-1:0] count_o,
    output logic         zero_o
);

    localparam logic [W-1:0] ONE = W'(1);

    logic [W-1:0] count_q, count_d;

    // NOTE: every variable assigned in always_comb gets a default first, so no
    // path can leave it unassigned and infer a latch.
    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (load_i) begin
            count_d = load_val_i;
        end else if (dec_i && (count_q != '0)) begin
            count_d = count_q - ONE;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers
    // update together from values sampled at the same edge.
    always_ff @(posedge clk) begin
        if (reset_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;
    assign zero_o  = (count_q == '0);

endmodule

// File: rtl/vector_sequencer.sv
// Plays back 3-bit control vectors from a registered ROM, holding each one for
// a programmable number of ticks (or until a manual step), with optional looping.
module vector_sequencer
    import vector_sequencer_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int HOLD_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              tick,
    input  logic              run_mode,
    input  logic              start,
    input  logic              step_mode,
    input  logic              step,
    input  logic              loop_en,
    input  logic [HOLD_W-1:0] hold_ticks,
    input  logic [ADDR_W-1:0] last_addr,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [MEM_W-1:0]  mem_q,
    output logic              hazard_out,
    output logic              turn_out,
    output logic              side_out,
    output logic              vec_valid,
    output logic              busy,
    output logic              done
);

    localparam logic [ADDR_W-1:0] ONE_A = ADDR_W'(1);
    localparam logic [HOLD_W-1:0] ONE_H = HOLD_W'(1);

    seq_state_e        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] last_q, last_d;
    logic              loop_q, loop_d;
    logic [VEC_W-1:0]  vec_q, vec_d;
    logic              valid_q, valid_d;

    logic [HOLD_W-1:0] hold_cnt;
    logic              hold_zero;
    logic [HOLD_W-1:0] hold_load_val;
    logic              ctr_load;
    logic              ctr_dec;
    logic              hold_end;

    // Only the low vector bits of the ROM word carry meaning.
    logic unused_mem_bits;
    assign unused_mem_bits = ^mem_q[MEM_W-1:VEC_W];

    assign hold_load_val = (hold_ticks == '0) ? ONE_H : hold_ticks;
    assign ctr_load      = run_mode && (state_q == ST_WAIT);
    assign ctr_dec       = run_mode && (state_q == ST_HOLD) && !step_mode && tick;

    // In step mode the counter is bypassed entirely, so a coincident tick
    // cannot add a second advance on top of the step.
    assign hold_end = step_mode ? step
                                : (tick && ((hold_cnt == ONE_H) || hold_zero));

    hold_down_counter #(
        .W (HOLD_W)
    ) u_hold_cnt (
        .clk        (clk),
        .reset_i    (reset),
        .clear_i    (!run_mode),
        .load_i     (ctr_load),
        .load_val_i (hold_load_val),
        .dec_i      (ctr_dec),
        .count_o    (hold_cnt),
        .zero_o     (hold_zero)
    );

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        last_d  = last_q;
        loop_d  = loop_q;
        vec_d   = vec_q;
        valid_d = valid_q;

        if (!run_mode) begin
            state_d = ST_IDLE;
            addr_d  = '0;
            vec_d   = '0;
            valid_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    addr_d  = '0;
                    vec_d   = '0;
                    valid_d = 1'b0;
                    if (start) begin
                        state_d = ST_FETCH;
                        last_d  = last_addr;
                        loop_d  = loop_en;
                    end
                end
                ST_FETCH: begin
                    state_d = ST_WAIT;
                end
                ST_WAIT: begin
                    vec_d[HAZ_BIT]  = mem_q[HAZ_BIT];
                    vec_d[TURN_BIT] = mem_q[TURN_BIT];
                    vec_d[SIDE_BIT] = mem_q[SIDE_BIT];
                    valid_d         = 1'b1;
                    state_d         = ST_HOLD;
                end
                ST_HOLD: begin
                    if (hold_end) begin
                        // Equality stop keeps last_addr = all-ones from wrapping.
                        if (addr_q != last_q) begin
                            addr_d  = addr_q + ONE_A;
                            state_d = ST_FETCH;
                        end else if (loop_q) begin
                            addr_d  = '0;
                            state_d = ST_FETCH;
                        end else begin
                            state_d = ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    if (start) begin
                        addr_d  = '0;
                        last_d  = last_addr;
                        loop_d  = loop_en;
                        state_d = ST_FETCH;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            last_q  <= '0;
            loop_q  <= 1'b0;
            vec_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            last_q  <= last_d;
            loop_q  <= loop_d;
            vec_q   <= vec_d;
            valid_q <= valid_d;
        end
    end

    assign mem_addr   = addr_q;
    assign hazard_out = vec_q[HAZ_BIT];
    assign turn_out   = vec_q[TURN_BIT];
    assign side_out   = vec_q[SIDE_BIT];
    assign vec_valid  = valid_q;
    assign busy       = (state_q == ST_FETCH) || (state_q == ST_WAIT) || (state_q == ST_HOLD);
    assign done       = (state_q == ST_DONE);

endmodule

// File: tb/tb_vector_sequencer.sv
// Scoreboard bench for vector_sequencer: stimulus pushes expected
// (address, vector, hold length) entries; a monitor pops one per vector capture.
module tb_vector_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       tick;
    logic       run_mode;
    logic       start;
    logic       step_mode;
    logic       step;
    logic       loop_en;
    logic [3:0] hold_ticks;
    logic [7:0] last_addr;
    logic [7:0] mem_addr;
    logic [7:0] mem_q;
    logic       hazard_out;
    logic       turn_out;
    logic       side_out;
    logic       vec_valid;
    logic       busy;
    logic       done;

    logic [7:0] rom [0:255];

    int n_tests = 0;
    int n_fail  = 0;
    int tick_period = 0;
    int tick_div    = 0;

    typedef struct {
        logic [7:0] addr;
        logic [2:0] vec;
        int         ticks;
    } exp_t;

    exp_t exp_q[$];

    vector_sequencer dut (
        .clk        (clk),
        .reset      (reset),
        .tick       (tick),
        .run_mode   (run_mode),
        .start      (start),
        .step_mode  (step_mode),
        .step       (step),
        .loop_en    (loop_en),
        .hold_ticks (hold_ticks),
        .last_addr  (last_addr),
        .mem_addr   (mem_addr),
        .mem_q      (mem_q),
        .hazard_out (hazard_out),
        .turn_out   (turn_out),
        .side_out   (side_out),
        .vec_valid  (vec_valid),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    // Registered ROM: data appears one clock after the address is sampled.
    always @(posedge clk) mem_q <= rom[mem_addr];

    task automatic check(input string name, input longint act, input longint exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push(input logic [7:0] a, input logic [2:0] v, input int t);
        exp_t e;
        e.addr  = a;
        e.vec   = v;
        e.ticks = t;
        exp_q.push_back(e);
    endtask

    task automatic pulse_start();
        @(posedge clk); #1; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
    endtask

    task automatic go_idle();
        @(posedge clk); #1; run_mode = 1'b0;
        @(posedge clk); #1; run_mode = 1'b1;
    endtask

    task automatic wait_sb(input int target, input int budget, input string name);
        int n = 0;
        while (exp_q.size() > target && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(name, exp_q.size(), target);
    endtask

    task automatic wait_done(input int budget, input string name);
        int n = 0;
        while (!done && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(name, done, 1);
    endtask

    // Tick divider model: one-cycle pulse every tick_period clocks (0 = none).
    initial begin
        tick = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (tick_period != 0 && tick_div >= tick_period - 1) begin
                tick     = 1'b1;
                tick_div = 0;
            end else begin
                tick = 1'b0;
                tick_div++;
            end
        end
    end

    // Monitor: a capture is any change of the presented vector while valid.
    logic [3:0] prev_out = '0;
    logic       in_hold  = 1'b0;
    logic [7:0] hold_addr;
    int         hold_exp;
    int         hold_evts;

    always @(negedge clk) begin : monitor
        logic [3:0] cur;
        exp_t       e;
        cur = {side_out, turn_out, hazard_out, vec_valid};
        if (in_hold && (mem_addr != hold_addr || done || !vec_valid)) begin
            if (hold_exp != 0) check("hold_length", hold_evts, hold_exp);
            in_hold = 1'b0;
        end
        if (vec_valid === 1'b1 && cur !== prev_out) begin
            check("capture_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("capture_addr", mem_addr, e.addr);
                check("capture_vec", {side_out, turn_out, hazard_out}, e.vec);
                in_hold   = 1'b1;
                hold_addr = mem_addr;
                hold_exp  = e.ticks;
                hold_evts = 0;
            end
        end
        if (in_hold && (step_mode ? step : tick)) hold_evts++;
        prev_out = cur;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int guard;

        for (int i = 0; i < 256; i++) rom[i] = 8'h00;
        rom[0] = 8'd1; rom[1] = 8'd2; rom[2] = 8'd6; rom[3] = 8'd0;

        // Reset must win over start/run_mode in the same cycle.
        reset = 1'b1; run_mode = 1'b1; start = 1'b1; step_mode = 1'b0; step = 1'b0;
        loop_en = 1'b0; hold_ticks = 4'd2; last_addr = 8'd3;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", {mem_addr, side_out, turn_out, hazard_out, vec_valid, busy, done}, 0);
        @(posedge clk); #1; reset = 1'b0; start = 1'b0;
        @(negedge clk);
        check("post_reset_idle", {busy, done, vec_valid}, 0);

        // Basic playback, no loop.
        tick_period = 4;
        push(8'd0, 3'd1, 2); push(8'd1, 3'd2, 2); push(8'd2, 3'd6, 2); push(8'd3, 3'd0, 2);
        pulse_start();
        wait_sb(0, 300, "basic_drain");
        wait_done(100, "basic_done");
        check("basic_done_vec", {side_out, turn_out, hazard_out, vec_valid, busy}, 5'b00010);

        // Restart from DONE, then reset while in WAIT.
        @(posedge clk); #1; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        @(negedge clk);
        check("fetch_keeps_vector", {busy, vec_valid, mem_addr}, {2'b11, 8'd0});
        @(posedge clk); #1; reset = 1'b1;
        @(negedge clk);
        check("wait_busy", busy, 1);
        @(posedge clk); #1; reset = 1'b0;
        @(negedge clk);
        check("reset_in_wait", {mem_addr, side_out, turn_out, hazard_out, vec_valid, busy, done}, 0);
        @(posedge clk); #1; reset = 1'b1; start = 1'b1;
        @(posedge clk); #1; reset = 1'b0; start = 1'b0;
        @(negedge clk);
        check("reset_beats_start", {busy, done}, 0);

        // Looping playback: addr 3 wraps to 0 and vector 1 reappears.
        loop_en = 1'b1;
        push(8'd0, 3'd1, 2); push(8'd1, 3'd2, 2); push(8'd2, 3'd6, 2); push(8'd3, 3'd0, 2);
        push(8'd0, 3'd1, 2); push(8'd1, 3'd2, 0);
        pulse_start();
        wait_sb(0, 400, "loop_drain");
        check("loop_not_done", {done, busy}, 2'b01);
        go_idle();
        loop_en = 1'b0;

        // run_mode dropped while holding addr 2, then restart.
        push(8'd0, 3'd1, 2); push(8'd1, 3'd2, 2); push(8'd2, 3'd6, 0);
        pulse_start();
        wait_sb(0, 300, "drop_drain");
        @(posedge clk); #1; run_mode = 1'b0;
        @(posedge clk); #1; run_mode = 1'b1;
        @(negedge clk);
        check("run_mode_drop", {mem_addr, side_out, turn_out, hazard_out, vec_valid, busy, done}, 0);
        push(8'd0, 3'd1, 2); push(8'd1, 3'd2, 2); push(8'd2, 3'd6, 2); push(8'd3, 3'd0, 2);
        pulse_start();
        wait_sb(0, 300, "restart_drain");
        wait_done(100, "restart_done");

        // Start while busy is ignored; hold_ticks change applies at next capture only.
        hold_ticks = 4'd3; tick_period = 2;
        push(8'd0, 3'd1, 3); push(8'd1, 3'd2, 3); push(8'd2, 3'd6, 3);
        pulse_start();
        wait_sb(1, 300, "busy_reach_addr1");
        pulse_start();
        wait_sb(0, 300, "busy_reach_addr2");
        @(posedge clk); #1; hold_ticks = 4'd1;
        push(8'd3, 3'd0, 1);
        wait_sb(0, 300, "busy_drain");
        wait_done(100, "busy_done");

        // Step mode with continuous ticks: one advance per step only.
        step_mode = 1'b1; tick_period = 1; hold_ticks = 4'd3;
        push(8'd0, 3'd1, 1); push(8'd1, 3'd2, 1); push(8'd2, 3'd6, 1); push(8'd3, 3'd0, 1);
        pulse_start();
        guard = 0;
        while (!done && guard < 20) begin
            repeat (9) @(posedge clk);
            #1; step = 1'b1;
            @(posedge clk); #1; step = 1'b0;
            guard++;
        end
        check("step_advances", guard, 4);
        wait_sb(0, 50, "step_drain");
        wait_done(50, "step_done");
        step_mode = 1'b0;

        // hold_ticks = 0 behaves as 1; measure start-to-valid latency.
        hold_ticks = 4'd0; tick_period = 3;
        push(8'd0, 3'd1, 1); push(8'd1, 3'd2, 1); push(8'd2, 3'd6, 1); push(8'd3, 3'd0, 1);
        @(posedge clk); #1; run_mode = 1'b0;
        @(posedge clk); #1; run_mode = 1'b1; start = 1'b1;
        @(negedge clk);
        check("latency_pre_valid", vec_valid, 0);
        @(posedge clk); #1; start = 1'b0; lat = 1;
        @(negedge clk);
        while (!vec_valid && lat < 10) begin
            @(posedge clk); #1; lat++;
            @(negedge clk);
        end
        check("start_to_valid_latency", lat, 3);
        wait_sb(0, 200, "hold0_drain");
        wait_done(100, "hold0_done");

        // Full address range: last_addr = 255 must stop, not wrap.
        go_idle();
        for (int i = 0; i < 256; i++) rom[i] = 8'(i % 8);
        last_addr = 8'd255; tick_period = 1;
        for (int i = 0; i < 256; i++) push(8'(i), 3'(i % 8), 1);
        pulse_start();
        wait_sb(0, 3000, "fullrange_drain");
        wait_done(100, "fullrange_done");
        check("fullrange_final", {side_out, turn_out, hazard_out, vec_valid, mem_addr}, {4'b1111, 8'd255});

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/vector_sequencer.md
VECTOR_SEQUENCER -- requirements
Module: vector_sequencer

Interface
REQ-001 Parameter ADDR_W, default 8, ROM address width.
REQ-002 Parameter HOLD_W, default 4, hold-count width.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 reset  input  1  reset is synchronous and active-high.
REQ-005 tick  input  1  one-cycle enable pulse from the clock divider, sets playback rate.
REQ-006 run_mode  input  1  1 = memory playback enabled, 0 = sequencer forced idle.
REQ-007 start  input  1  one-cycle pulse, begins playback at address 0.
REQ-008 step_mode  input  1  1 = advance on step only, tick ignored in HOLD.
REQ-009 step  input  1  one-cycle manual advance pulse.
REQ-010 loop_en  input  1  1 = wrap to address 0 after last_addr, 0 = stop.
REQ-011 hold_ticks  input  HOLD_W  ticks each vector is held; 0 treated as 1.
REQ-012 last_addr  input  ADDR_W  final vector address, inclusive.
REQ-013 mem_addr  output  ADDR_W  address to the registered ROM.
REQ-014 mem_q  input  8  ROM data, valid one clk after mem_addr is sampled.
REQ-015 hazard_out / turn_out / side_out  output  1 each  registered vector bits mem_q[0] / [1] / [2].
REQ-016 vec_valid  output  1  high while a captured vector is presented.
REQ-017 busy  output  1  high in FETCH, WAIT, HOLD.
REQ-018 done  output  1  high in DONE.

Function
REQ-019 States: IDLE, FETCH, WAIT, HOLD, DONE; all transitions registered.
REQ-020 IDLE: mem_addr=0, vector outputs 0, vec_valid=0; start with run_mode=1 -> FETCH, addr=0, last_addr and loop_en latched.
REQ-021 FETCH: drive mem_addr=addr for one cycle -> WAIT.
REQ-022 WAIT: at end of cycle capture mem_q[2:0] into vector outputs, load hold counter = max(hold_ticks,1) -> HOLD.
REQ-023 Start-to-vec_valid latency exactly 3 clk (start in cycle N, vec_valid high in cycle N+3).
REQ-024 HOLD, step_mode=0: counter decrements on each tick; the tick that takes counter 1->0 ends the hold.
REQ-025 HOLD, step_mode=1: counter ignored; step ends the hold; tick and step simultaneous -> step acts once only.
REQ-026 Hold end with addr!=latched last_addr -> addr+1, FETCH.
REQ-027 Hold end with addr==latched last_addr: loop_en latched 1 -> addr=0, FETCH; else DONE.
REQ-028 Vector outputs and vec_valid stay stable through FETCH/WAIT of the next vector, updating only at WAIT capture.
REQ-029 DONE: last vector held, vec_valid=1, done=1; start -> FETCH addr 0.
REQ-030 start while busy is ignored.
REQ-031 run_mode=0 in any state -> IDLE next clk, outputs cleared, no ROM capture.
REQ-032 last_addr=2^ADDR_W-1 terminates by equality compare, no address overflow.
REQ-033 Changes to hold_ticks take effect at the next WAIT capture only.

Reset
REQ-034 reset=1 at a clk edge -> IDLE, addr=0, counter=0, all outputs 0, regardless of state.
REQ-035 reset overrides start, step, tick and run_mode in the same cycle.

Structure
REQ-036 Shared package holds state encodings and the vector bit indices (HAZ_BIT=0, TURN_BIT=1, SIDE_BIT=2).
REQ-037 One sub-module, hold_down_counter (load, tick-enable decrement, zero flag), instantiated once.

Verification
REQ-038 hold_ticks=2, last_addr=3, loop_en=0, ROM {1,2,6,0}, tick every 4 clk, start -> vectors 1,2,6,0 each held 2 ticks, then done=1 with vector 0.
REQ-039 Same ROM, loop_en=1 -> after addr 3, addr 0 refetched, vector 1 reappears, done stays 0.
REQ-040 step_mode=1, tick continuous, step every 10 clk -> one address advance per step, none per tick; tick+step same cycle -> single advance.
REQ-041 run_mode dropped in HOLD at addr 2 -> next clk IDLE, outputs 0, mem_addr 0; start again -> restart at addr 0.
REQ-042 reset asserted in WAIT -> next clk all outputs 0, state IDLE; start during busy -> addr sequence unchanged.
REQ-043 hold_ticks=0 -> each vector held exactly 1 tick; start to vec_valid measured as 3 clk.
